// File: rtl/array_arbiter_pkg.sv
// rtl/array_arbiter_pkg.sv - shared types and width helper for the array read-port arbiter
//
// Purpose : FSM state encoding and a clog2-based width helper shared by
//           array_arbiter and rr_pick.
// Ports   : none (package)

package array_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   // Ceiling log2 of n, never less than 1 so that index and counter
   // vectors always have at least one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose : choose one active requester, searching upward from the one
//           after last_grant and wrapping modulo N_REQ.
// Ports   : req        - request vector
//           last_grant - index of the previously granted requester
//           grant      - one-hot grant (all zero when nothing is requested)
//           idx        - binary index of the granted requester
//           any        - at least one request is active

module rr_pick
   import array_arbiter_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IW    = clog2_min1(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    idx,
   output logic             any
);

   // Outer loop walks the search order (distance from last_grant), inner
   // loop finds the requester at that distance; the first hit wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i] && (i == ((int'(last_grant) + k) % N_REQ))) begin
               any      = 1'b1;
               idx      = IW'(i);
               grant[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/array_arbiter.sv
// rtl/array_arbiter.sv - round-robin arbiter sharing one array read port
//
// Purpose : grants one of N_REQ requesters at a time, drives its address to
//           the shared array, waits LAT cycles for the read data, and holds
//           the captured word as a response until the consumer accepts it.
// Ports   : clk, rst               - clock, asynchronous active-low reset
//           req_valid/req_addr     - per-requester read requests
//           req_ready              - one-hot grant, IDLE only
//           arr_addr/arr_data      - shared array read port
//           resp_valid/resp_ready  - response handshake
//           resp_data/resp_id      - captured word and owning requester

module array_arbiter
   import array_arbiter_pkg::*;
#(
   parameter int N_REQ      = 2,
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 25,
   parameter int LAT        = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
   output logic [N_REQ-1:0]              req_ready,
   output logic [ADDR_WIDTH-1:0]         arr_addr,
   input  logic [DATA_WIDTH-1:0]         arr_data,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic [clog2_min1(N_REQ)-1:0]  resp_id
);

   localparam int            IW       = clog2_min1(N_REQ);
   localparam int            CW       = clog2_min1(LAT + 1);
   localparam logic [CW-1:0] LAT_CNT  = CW'(LAT);
   localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

   arb_state_e              state;
   logic [CW-1:0]           cnt;
   logic [IW-1:0]           last_grant;
   logic [N_REQ-1:0]        pick_grant;
   logic [IW-1:0]           pick_idx;
   logic                    pick_any;
   logic [ADDR_WIDTH-1:0]   sel_addr;

   rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (pick_grant),
      .idx        (pick_idx),
      .any        (pick_any)
   );

   // Address mux driven by the one-hot grant; no arithmetic on the address.
   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_grant[i]) sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   // rst is folded in so the grant drops the moment reset asserts, not at
   // the next edge. pick_grant is already qualified by req_valid.
   assign req_ready  = (rst && (state == IDLE)) ? pick_grant : '0;
   assign resp_valid = (state == RESP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= LAST_RST;
         arr_addr   <= '0;
         resp_data  <= '0;
         resp_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  arr_addr   <= sel_addr;
                  resp_id    <= pick_idx;
                  last_grant <= pick_idx;
                  // The grant edge itself is the first of the LAT counts.
                  cnt        <= CW'(1);
                  state      <= READ;
               end
            end
            READ: begin
               if (cnt == LAT_CNT) begin
                  resp_data <= arr_data;
                  cnt       <= '0;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESP: begin
               if (resp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_array_arbiter.sv
// tb/tb_array_arbiter.sv - self-checking bench for array_arbiter

module tb_array_arbiter;

   localparam int N    = 2;
   localparam int AW   = 2;
   localparam int DW   = 25;
   localparam int LAT1 = 1;
   localparam int LAT3 = 3;

   logic            clk = 1'b0;
   logic            rst;

   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    req_ready;
   logic [AW-1:0]   arr_addr;
   logic [DW-1:0]   arr_data;
   logic            resp_valid;
   logic            resp_ready;
   logic [DW-1:0]   resp_data;
   logic [0:0]      resp_id;

   logic [N-1:0]    rv3;
   logic [N*AW-1:0] ra3;
   logic [N-1:0]    rdy3;
   logic [AW-1:0]   arr_addr3;
   logic [DW-1:0]   arr_data3;
   logic            rvalid3;
   logic            rready3;
   logic [DW-1:0]   rdata3;
   logic [0:0]      rid3;
   logic [AW-1:0]   pipe3_a;
   logic [AW-1:0]   pipe3_b;

   int checks   = 0;
   int failures = 0;
   int cyc_n    = 0;

   int m_free, m_pend, m_wait, m_last, m_addr, m_id, m_data;

   logic [N-1:0]    obs_rr;
   logic            obs_rv;
   logic [DW-1:0]   obs_data;
   logic [0:0]      obs_id;

   int seen_data[$];
   int seen_id[$];
   int seen_cyc[$];

   int sweep_addr[5] = '{0, 1, 2, 3, 0};
   int sweep_data[5] = '{1, 17, 33, 49, 1};
   int cont_id[4]    = '{0, 1, 0, 1};
   int cont_data[4]  = '{17, 49, 17, 49};

   always #5 clk = ~clk;

   array_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAT(LAT1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .arr_addr   (arr_addr),
      .arr_data   (arr_data),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id)
   );

   array_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAT(LAT3)) dut3 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (rv3),
      .req_addr   (ra3),
      .req_ready  (rdy3),
      .arr_addr   (arr_addr3),
      .arr_data   (arr_data3),
      .resp_valid (rvalid3),
      .resp_ready (rready3),
      .resp_data  (rdata3),
      .resp_id    (rid3)
   );

   // Array stubs: word at address a is 16*a+1, visible LAT cycles after the
   // address is registered (LAT-1 pipeline stages plus a combinational read).
   assign arr_data = {19'd0, arr_addr, 4'd1};

   always @(posedge clk) begin
      pipe3_a <= arr_addr3;
      pipe3_b <= pipe3_a;
   end
   assign arr_data3 = {19'd0, pipe3_b, 4'd1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   function automatic int model_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last + k) % N;
         if (((int'(v) >> c) & 1) == 1) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_free = 1;
      m_pend = 0;
      m_wait = 0;
      m_last = N - 1;
      m_addr = 0;
      m_id   = 0;
      m_data = 0;
   endtask

   // One clock of the LAT=1 DUT against the transaction model. Entered and
   // left at posedge+1 with inputs already set for this cycle.
   task automatic run_cycle();
      int p;
      int exp_rr;
      int exp_rv;
      #1;
      p      = (m_free == 1) ? model_pick(req_valid, m_last) : -1;
      exp_rr = (p >= 0) ? (1 << p) : 0;
      exp_rv = (m_pend == 1 && m_wait == 0) ? 1 : 0;
      chk("req_ready", 32'(req_ready), exp_rr);
      chk("resp_valid", 32'(resp_valid), exp_rv);
      chk("arr_addr", 32'(arr_addr), m_addr);
      if (exp_rv == 1) begin
         chk("resp_data", 32'(resp_data), m_data);
         chk("resp_id", 32'(resp_id), m_id);
      end
      obs_rr   = req_ready;
      obs_rv   = resp_valid;
      obs_data = resp_data;
      obs_id   = resp_id;
      if (resp_valid && resp_ready) begin
         seen_data.push_back(int'(resp_data));
         seen_id.push_back(int'(resp_id));
         seen_cyc.push_back(cyc_n);
      end
      @(posedge clk);
      cyc_n++;
      if (p >= 0) begin
         m_free = 0;
         m_pend = 1;
         m_wait = LAT1;
         m_id   = p;
         m_addr = (int'(req_addr) >> (p * AW)) & 3;
         m_data = 16 * m_addr + 1;
         m_last = p;
      end else if (m_pend == 1) begin
         if (m_wait > 0) m_wait--;
         else if (resp_ready) begin
            m_pend = 0;
            m_free = 1;
         end
      end
      #1;
   endtask

   task automatic clear_seen();
      seen_data.delete();
      seen_id.delete();
      seen_cyc.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc_n);
      $fatal(1, "watchdog");
   end

   initial begin
      int g0;
      rst        = 1'b0;
      req_valid  = 2'b11;
      req_addr   = 4'b0110;
      resp_ready = 1'b1;
      rv3        = 2'b00;
      ra3        = 4'b0000;
      rready3    = 1'b1;
      model_reset();

      // Reset state, with requests active to show the grant is held off.
      #3;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_arr_addr", 32'(arr_addr), 0);
      chk("rst_resp_data", 32'(resp_data), 0);
      chk("rst_resp_id", 32'(resp_id), 0);
      @(posedge clk); #1;
      rst       = 1'b1;
      req_valid = 2'b00;

      // Single request: req0, addr 2.
      clear_seen();
      req_valid = 2'b01;
      req_addr  = {2'd0, 2'd2};
      run_cycle();
      g0 = cyc_n - 1;
      chk("single_pulse", 32'(obs_rr), 1);
      req_valid = 2'b00;
      for (int i = 0; i < 3; i++) run_cycle();
      chk("single_count", seen_data.size(), 1);
      if (seen_data.size() >= 1) begin
         chk("single_data", seen_data[0], 33);
         chk("single_id", seen_id[0], 0);
         chk("single_delay", seen_cyc[0] - g0, 2);
      end

      // Backpressure: response on req1 held for 5 cycles with both requesting.
      resp_ready = 1'b0;
      req_valid  = 2'b10;
      req_addr   = {2'd3, 2'd0};
      run_cycle();
      chk("bp_grant", 32'(obs_rr), 2);
      req_valid = 2'b11;
      run_cycle();
      for (int i = 0; i < 5; i++) begin
         run_cycle();
         chk("bp_valid", 32'(obs_rv), 1);
         chk("bp_data", 32'(obs_data), 49);
         chk("bp_id", 32'(obs_id), 1);
         chk("bp_no_grant", 32'(obs_rr), 0);
      end
      resp_ready = 1'b1;
      req_valid  = 2'b00;
      run_cycle();
      run_cycle();

      // Address sweep on requester 1, including the wrap back to 0.
      clear_seen();
      for (int s = 0; s < 5; s++) begin
         req_addr  = {2'(sweep_addr[s]), 2'd0};
         req_valid = 2'b10;
         for (int t = 0; t < 10; t++) begin
            run_cycle();
            if (obs_rr[1]) break;
         end
         chk("sweep_grant", 32'(obs_rr), 2);
         req_valid = 2'b00;
      end
      for (int i = 0; i < 4; i++) run_cycle();
      chk("sweep_count", seen_data.size(), 5);
      for (int s = 0; s < 5 && s < seen_data.size(); s++)
         chk("sweep_data", seen_data[s], sweep_data[s]);

      // Random traffic, including req_valid changes mid-transaction.
      for (int i = 0; i < 400; i++) begin
         req_valid  = 2'($urandom_range(0, 3));
         req_addr   = 4'($urandom_range(0, 15));
         resp_ready = ($urandom_range(0, 3) != 0);
         run_cycle();
      end
      req_valid  = 2'b00;
      resp_ready = 1'b1;
      for (int i = 0; i < 10 && m_free == 0; i++) run_cycle();
      chk("random_drain", m_free, 1);

      // Reset while the read for requester 0 is in flight.
      req_valid = 2'b01;
      req_addr  = {2'd3, 2'd2};
      run_cycle();
      chk("rst_pre_grant", 32'(obs_rr), 1);
      req_valid = 2'b11;
      #1;
      rst = 1'b0;
      #1;
      chk("mid_rst_req_ready", 32'(req_ready), 0);
      chk("mid_rst_resp_valid", 32'(resp_valid), 0);
      chk("mid_rst_arr_addr", 32'(arr_addr), 0);
      chk("mid_rst_resp_data", 32'(resp_data), 0);
      chk("mid_rst_resp_id", 32'(resp_id), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      cyc_n++;
      model_reset();

      // Contention straight after reset: ids alternate starting at 0.
      clear_seen();
      req_addr   = {2'd3, 2'd1};
      req_valid  = 2'b11;
      resp_ready = 1'b1;
      for (int i = 0; i < 40 && seen_data.size() < 4; i++) run_cycle();
      chk("cont_count", seen_data.size(), 4);
      for (int i = 0; i < 4 && i < seen_data.size(); i++) begin
         chk("cont_id", seen_id[i], cont_id[i]);
         chk("cont_data", seen_data[i], cont_data[i]);
         if (i > 0) chk("cont_spacing", seen_cyc[i] - seen_cyc[i-1], LAT1 + 2);
      end
      req_valid = 2'b00;
      for (int i = 0; i < 4; i++) run_cycle();

      // LAT=3 instance: single request at addr 3.
      @(posedge clk); #1;
      rv3     = 2'b01;
      ra3     = {2'd0, 2'd3};
      rready3 = 1'b1;
      #1;
      chk("lat3_grant", 32'(rdy3), 1);
      @(posedge clk); #1;
      rv3 = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) begin
            @(posedge clk); #1;
         end
         chk("lat3_valid", 32'(rvalid3), (k == 4) ? 32'd1 : 32'd0);
         chk("lat3_no_regrant", 32'(rdy3), 0);
      end
      chk("lat3_data", 32'(rdata3), 49);
      chk("lat3_id", 32'(rid3), 0);
      chk("lat3_addr", 32'(arr_addr3), 3);
      @(posedge clk); #1;
      chk("lat3_accepted", 32'(rvalid3), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/array_arbiter.md
ARRAY_ARBITER -- requirements
Module: array_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of requesters sharing the array read port (2..8).
REQ-002 Parameter ADDR_WIDTH, default 2: array address width.
REQ-003 Parameter DATA_WIDTH, default 25: width of the fixed-point array data word, passed through unmodified.
REQ-004 Parameter LAT, default 1: array read latency in clk cycles (1..4).
REQ-005 clk  input  1: single clock; all state updates on its rising edge.
REQ-006 rst  input  1: asynchronous, active-low reset (asserted when 0).
REQ-007 req_valid  input  N_REQ: requester i has a pending read.
REQ-008 req_addr  input  N_REQ*ADDR_WIDTH: requester i address, slice i.
REQ-009 req_ready  output  N_REQ: one-hot grant; request i is accepted when req_valid[i] and req_ready[i] are both 1.
REQ-010 arr_addr  output  ADDR_WIDTH: address driven to the shared array.
REQ-011 arr_data  input  DATA_WIDTH: array read data, valid LAT cycles after arr_addr is sampled.
REQ-012 resp_valid  output  1: response holding.
REQ-013 resp_ready  input  1: consumer accepts the response.
REQ-014 resp_data  output  DATA_WIDTH: captured array word.
REQ-015 resp_id  output  clog2(N_REQ) (minimum 1): index of the requester that owns the response.

Function
REQ-016 FSM states SHALL be IDLE, READ and RESP.
REQ-017 IDLE: if any req_valid is set, assert req_ready for exactly one requester chosen round-robin, latch its address into arr_addr and its index, then go to READ; otherwise stay in IDLE.
REQ-018 Round-robin: search starts at (last_grant+1) mod N_REQ; last_grant resets to N_REQ-1, so requester 0 wins first.
REQ-019 req_ready SHALL be asserted only in IDLE, for at most one cycle per transaction, and is combinationally gated by req_valid.
REQ-020 READ: count LAT cycles from the grant edge; on the last count, capture arr_data into resp_data and go to RESP.
REQ-021 RESP: resp_valid=1; resp_data and resp_id SHALL be stable until resp_ready=1, then go to IDLE.
REQ-022 Throughput: one transaction every LAT+2 cycles minimum; no new grant while in READ or RESP.
REQ-023 arr_addr SHALL hold the granted address from the grant until the next grant.
REQ-024 A req_valid deassertion during READ/RESP SHALL NOT affect the transaction in flight.
REQ-025 Latency counter width SHALL be clog2(LAT+1); the counter SHALL NOT wrap past LAT.
REQ-026 Address SHALL be passed through without arithmetic; all ADDR_WIDTH values, including 2^ADDR_WIDTH-1, SHALL be legal.

Reset
REQ-027 On rst=0, immediately: state=IDLE, req_ready=0, resp_valid=0, resp_data=0, resp_id=0, arr_addr=0, latency counter=0, last_grant=N_REQ-1.
REQ-028 Reset mid-transaction SHALL abandon it with no response; after rst returns to 1, the block resumes from IDLE on the next edge.

Structure
REQ-029 Package array_arbiter_pkg SHALL hold the FSM state enum (IDLE, READ, RESP) and a clog2-based width helper constant function.
REQ-030 Sub-module rr_pick SHALL implement the combinational round-robin picker (inputs: request vector, last_grant; outputs: one-hot grant, index, any).

Verification
Bench uses an array stub with latency LAT, where data at address a is 16*a+1.
REQ-031 Single request: N_REQ=2, LAT=1, req0 addr=2 -> req_ready[0] pulses for 1 cycle; resp_valid 2 cycles later with data 33, id 0.
REQ-032 Contention: req0 and req1 held valid, addresses 1 and 3, resp_ready=1 -> responses with ids 0,1,0,1 and data 17,49,17,49, spaced LAT+2 cycles apart.
REQ-033 Backpressure: resp_ready=0 for 5 cycles -> resp_valid, resp_data and resp_id held constant; no req_ready pulses until acceptance.
REQ-034 Address sweep: one requester issues addresses 0,1,2,3,0 (wrap) -> data 1,17,33,49,1.
REQ-035 Reset mid-READ: drop rst for 1 cycle -> all outputs 0 immediately; no response from the abandoned transaction; next grant goes to requester 0.
REQ-036 LAT=3: single request at addr 3 -> resp_data 49 appears exactly 4 cycles after the grant edge.
